// File: rtl/engine_read_arbiter.sv
// Round-robin arbiter sharing one AXI read-address/read-data channel between several engines.
// Burst IDs are tagged with the engine index on the way out; returning beats are steered by that tag.
module engine_read_arbiter #(
    parameter int NUM_ENGINES     = 4,
    parameter int ENG_W           = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [6*NUM_ENGINES-1:0]   rd_id_in,
    input  logic [33*NUM_ENGINES-1:0]  rd_addr_in,
    input  logic [8*NUM_ENGINES-1:0]   rd_len_in,
    input  logic [NUM_ENGINES-1:0]     rd_info_valid_in,
    output logic [NUM_ENGINES-1:0]     rd_info_rdy_out,
    output logic [255:0]               rd_data_out,
    output logic [NUM_ENGINES-1:0]     rd_data_valid_out,
    input  logic [NUM_ENGINES-1:0]     rd_data_rdy_in,
    output logic [6+ENG_W-1:0]         ar_id_out,
    output logic [32:0]                ar_addr_out,
    output logic [7:0]                 ar_len_out,
    output logic                       ar_valid_out,
    input  logic                       ar_ready_in,
    input  logic [6+ENG_W-1:0]         r_id_in,
    input  logic [255:0]               r_data_in,
    input  logic                       r_last_in,
    input  logic                       r_valid_in,
    output logic                       r_ready_out,
    output logic                       err_bad_id_out
);

    localparam int IDW = 6 + ENG_W;
    localparam int CW  = 4;

    // Handshake rule on both channels: a transfer happens in the cycle where valid and ready are
    // both high; the sender holds its payload stable while valid is high and ready is low.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           cnt [NUM_ENGINES];
    logic [ENG_W-1:0]        rr_ptr;
    logic [ENG_W-1:0]        winner;
    logic                    any_elig;
    logic                    load;
    logic [5:0]              sel_id;
    logic [32:0]             sel_addr;
    logic [7:0]              sel_len;
    logic [NUM_ENGINES-1:0]  elig;
    logic [NUM_ENGINES-1:0]  inc;
    logic [NUM_ENGINES-1:0]  dec;
    logic [ENG_W-1:0]        ret_eng;
    logic                    ret_hit;
    logic                    unused_id_bits;

    assign ret_eng        = r_id_in[IDW-1:6];
    assign unused_id_bits = ^r_id_in[5:0];
    assign ar_valid_out   = (state == FULL);

    always_comb begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
            elig[i] = rd_info_valid_in[i] && (cnt[i] < CW'(MAX_OUTSTANDING));
        end
    end

    // First eligible engine at or after rr_ptr, wrapping at NUM_ENGINES-1.
    always_comb begin
        int idx;
        idx      = 0;
        any_elig = 1'b0;
        winner   = '0;
        sel_id   = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_ENGINES) idx = idx - NUM_ENGINES;
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                winner   = ENG_W'(idx);
                sel_id   = rd_id_in[6*idx +: 6];
                sel_addr = rd_addr_in[33*idx +: 33];
                sel_len  = rd_len_in[8*idx +: 8];
            end
        end
    end

    assign load = rst && any_elig && ((state == EMPTY) || ar_ready_in);

    always_comb begin
        state_next      = state;
        rd_info_rdy_out = '0;
        inc             = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (load && (winner == ENG_W'(i))) begin
                rd_info_rdy_out[i] = 1'b1;
                inc[i]             = 1'b1;
            end
        end
        if (load) begin
            state_next = FULL;
        end else if ((state == FULL) && ar_ready_in) begin
            state_next = EMPTY;
        end
    end

    // Return path: unbuffered steering; beats tagged with a nonexistent engine are swallowed.
    always_comb begin
        rd_data_out       = r_data_in;
        rd_data_valid_out = '0;
        r_ready_out       = 1'b0;
        ret_hit           = 1'b0;
        dec               = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (ret_eng == ENG_W'(i)) begin
                ret_hit              = 1'b1;
                rd_data_valid_out[i] = r_valid_in;
                r_ready_out          = rd_data_rdy_in[i];
                dec[i]               = r_valid_in && rd_data_rdy_in[i] && r_last_in;
            end
        end
        if (!ret_hit) r_ready_out = 1'b1;
        if (!rst) begin
            rd_data_valid_out = '0;
            r_ready_out       = 1'b0;
            dec               = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= EMPTY;
            rr_ptr         <= '0;
            ar_id_out      <= '0;
            ar_addr_out    <= '0;
            ar_len_out     <= '0;
            err_bad_id_out <= 1'b0;
            for (int i = 0; i < NUM_ENGINES; i++) cnt[i] <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                ar_id_out   <= {winner, sel_id};
                ar_addr_out <= sel_addr;
                ar_len_out  <= sel_len;
                rr_ptr      <= (winner == ENG_W'(NUM_ENGINES - 1)) ? '0 : winner + 1'b1;
            end
            if (r_valid_in && !ret_hit) err_bad_id_out <= 1'b1;
            // Simultaneous grant and burst completion cancel out; completion at zero is ignored.
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec[i] && !inc[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_engine_read_arbiter.sv
// Directed bench for engine_read_arbiter: a 4-engine instance for the main function and a
// 3-engine instance for the out-of-range return tag.
module tb_engine_read_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [23:0]  rd_id = '0;
    logic [131:0] rd_addr = '0;
    logic [31:0]  rd_len = '0;
    logic [3:0]   rd_vld = '0;
    logic [3:0]   rd_rdy;
    logic [255:0] rd_dout;
    logic [3:0]   rd_dvld;
    logic [3:0]   rd_drdy = '0;
    logic [7:0]   ar_id;
    logic [32:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         ar_valid;
    logic         ar_ready = 1'b0;
    logic [7:0]   r_id = '0;
    logic [255:0] r_data = '0;
    logic         r_last = 1'b0;
    logic         r_valid = 1'b0;
    logic         r_ready;
    logic         err;

    logic [17:0]  rd_id3 = '0;
    logic [98:0]  rd_addr3 = '0;
    logic [23:0]  rd_len3 = '0;
    logic [2:0]   rd_vld3 = '0;
    logic [2:0]   rd_rdy3;
    logic [255:0] rd_dout3;
    logic [2:0]   rd_dvld3;
    logic [2:0]   rd_drdy3 = '0;
    logic [7:0]   ar_id3;
    logic [32:0]  ar_addr3;
    logic [7:0]   ar_len3;
    logic         ar_valid3;
    logic         r_ready3;
    logic         err3;

    int checks = 0;
    int errors = 0;
    int exp_eng [6] = '{1, 2, 3, 0, 1, 2};
    logic [255:0] pattern;

    always #5 clk = ~clk;

    engine_read_arbiter #(.NUM_ENGINES(4), .ENG_W(2), .MAX_OUTSTANDING(8)) dut (
        .clk(clk), .rst(rst),
        .rd_id_in(rd_id), .rd_addr_in(rd_addr), .rd_len_in(rd_len),
        .rd_info_valid_in(rd_vld), .rd_info_rdy_out(rd_rdy),
        .rd_data_out(rd_dout), .rd_data_valid_out(rd_dvld), .rd_data_rdy_in(rd_drdy),
        .ar_id_out(ar_id), .ar_addr_out(ar_addr), .ar_len_out(ar_len),
        .ar_valid_out(ar_valid), .ar_ready_in(ar_ready),
        .r_id_in(r_id), .r_data_in(r_data), .r_last_in(r_last), .r_valid_in(r_valid),
        .r_ready_out(r_ready), .err_bad_id_out(err)
    );

    engine_read_arbiter #(.NUM_ENGINES(3), .ENG_W(2), .MAX_OUTSTANDING(8)) dut3 (
        .clk(clk), .rst(rst),
        .rd_id_in(rd_id3), .rd_addr_in(rd_addr3), .rd_len_in(rd_len3),
        .rd_info_valid_in(rd_vld3), .rd_info_rdy_out(rd_rdy3),
        .rd_data_out(rd_dout3), .rd_data_valid_out(rd_dvld3), .rd_data_rdy_in(rd_drdy3),
        .ar_id_out(ar_id3), .ar_addr_out(ar_addr3), .ar_len_out(ar_len3),
        .ar_valid_out(ar_valid3), .ar_ready_in(ar_ready),
        .r_id_in(r_id), .r_data_in(r_data), .r_last_in(r_last), .r_valid_in(r_valid),
        .r_ready_out(r_ready3), .err_bad_id_out(err3)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: registers cleared and combinational outputs suppressed.
        rd_vld  = 4'b0001;
        rd_id[5:0] = 6'd5;
        r_valid = 1'b1;
        r_id    = 8'h00;
        rd_drdy = 4'b1111;
        #2;
        check("rst_ar_valid", 256'(ar_valid), 256'(0));
        check("rst_ar_id", 256'(ar_id), 256'(0));
        check("rst_ar_addr", 256'(ar_addr), 256'(0));
        check("rst_ar_len", 256'(ar_len), 256'(0));
        check("rst_rdy", 256'(rd_rdy), 256'(0));
        check("rst_dvld", 256'(rd_dvld), 256'(0));
        check("rst_r_ready", 256'(r_ready), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        tick();
        tick();
        check("rst_hold_ar_valid", 256'(ar_valid), 256'(0));
        rd_vld  = '0;
        r_valid = 1'b0;
        rd_drdy = '0;
        rst     = 1'b1;
        tick();

        // Single request from engine 0.
        rd_id[5:0]    = 6'd5;
        rd_addr[32:0] = 33'h100;
        rd_len[7:0]   = 8'd3;
        rd_vld        = 4'b0001;
        ar_ready      = 1'b1;
        #1;
        check("single_rdy", 256'(rd_rdy), 256'(4'b0001));
        tick();
        rd_vld = '0;
        check("single_ar_valid", 256'(ar_valid), 256'(1));
        check("single_ar_id", 256'(ar_id), 256'(8'h05));
        check("single_ar_addr", 256'(ar_addr), 256'(33'h100));
        check("single_ar_len", 256'(ar_len), 256'(3));
        tick();
        check("single_drain", 256'(ar_valid), 256'(0));

        // Fairness: all engines valid, rr_ptr now points at engine 1.
        for (int i = 0; i < 4; i++) begin
            rd_id[6*i +: 6]    = 6'h10 + 6'(i);
            rd_addr[33*i +: 33] = 33'h1000 * 33'(i + 1);
            rd_len[8*i +: 8]   = 8'(i + 1);
        end
        rd_vld = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fair_rdy", 256'(rd_rdy), 256'(4'b0001 << exp_eng[k]));
            tick();
            check("fair_ar_id", 256'(ar_id), 256'({2'(exp_eng[k]), 6'h10 + 6'(exp_eng[k])}));
            check("fair_ar_addr", 256'(ar_addr), 256'(33'h1000 * 33'(exp_eng[k] + 1)));
        end

        // Back-pressure: slot holds engine 2's burst, no new grants.
        ar_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rdy", 256'(rd_rdy), 256'(0));
            tick();
            check("bp_ar_valid", 256'(ar_valid), 256'(1));
            check("bp_ar_id", 256'(ar_id), 256'(8'h92));
            check("bp_ar_len", 256'(ar_len), 256'(3));
        end
        ar_ready = 1'b1;
        #1;
        check("bp_release_rdy", 256'(rd_rdy), 256'(4'b1000));
        tick();
        check("bp_release_ar_id", 256'(ar_id), 256'(8'hD3));
        rd_vld = '0;
        tick();
        check("bp_drain", 256'(ar_valid), 256'(0));

        // Outstanding limit: engine 1 goes from 2 to 8 bursts in flight.
        rd_vld = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("lim_fill_rdy", 256'(rd_rdy), 256'(4'b0010));
            tick();
            check("lim_fill_ar_id", 256'(ar_id), 256'(8'h51));
        end
        rd_vld = 4'b0011;
        #1;
        check("lim_other_rdy", 256'(rd_rdy), 256'(4'b0001));
        tick();
        check("lim_other_ar_id", 256'(ar_id), 256'(8'h10));
        rd_vld  = 4'b0010;
        r_id    = {2'd1, 6'd0};
        r_last  = 1'b1;
        r_valid = 1'b1;
        rd_drdy = 4'b0010;
        #1;
        check("lim_blocked_rdy", 256'(rd_rdy), 256'(0));
        check("lim_ret_dvld", 256'(rd_dvld), 256'(4'b0010));
        check("lim_ret_r_ready", 256'(r_ready), 256'(1));
        tick();
        r_valid = 1'b0;
        r_last  = 1'b0;
        #1;
        check("lim_freed_rdy", 256'(rd_rdy), 256'(4'b0010));
        tick();
        check("lim_freed_ar_id", 256'(ar_id), 256'(8'h51));
        rd_vld = '0;

        // Routing to engine 2, then back-pressure from engine 2.
        pattern = {8{32'hC0FFEE11}} ^ 256'h1234_5678;
        r_id    = {2'd2, 6'd9};
        r_data  = pattern;
        r_valid = 1'b1;
        rd_drdy = 4'b1111;
        #1;
        check("route_dvld", 256'(rd_dvld), 256'(4'b0100));
        check("route_r_ready", 256'(r_ready), 256'(1));
        check("route_data", rd_dout, pattern);
        rd_drdy = 4'b1011;
        #1;
        check("route_bp_r_ready", 256'(r_ready), 256'(0));
        check("route_bp_dvld", 256'(rd_dvld), 256'(4'b0100));
        tick();
        r_valid = 1'b0;

        // Out-of-range tag on the 3-engine instance.
        check("bad_err_before", 256'(err3), 256'(0));
        r_id    = {2'd3, 6'd0};
        r_valid = 1'b1;
        rd_drdy = '0;
        #1;
        check("bad_r_ready", 256'(r_ready3), 256'(1));
        check("bad_dvld", 256'(rd_dvld3), 256'(0));
        tick();
        r_valid = 1'b0;
        check("bad_err_set", 256'(err3), 256'(1));
        tick();
        check("bad_err_sticky", 256'(err3), 256'(1));
        check("good_err_clear", 256'(err), 256'(0));

        // Reset while FULL.
        rd_vld   = 4'b0001;
        ar_ready = 1'b0;
        #1;
        check("rstfull_rdy", 256'(rd_rdy), 256'(4'b0001));
        tick();
        check("rstfull_ar_valid_pre", 256'(ar_valid), 256'(1));
        rst = 1'b0;
        #1;
        check("rstfull_ar_valid", 256'(ar_valid), 256'(0));
        check("rstfull_ar_id", 256'(ar_id), 256'(0));
        check("rstfull_err", 256'(err3), 256'(0));
        check("rstfull_rdy_forced", 256'(rd_rdy), 256'(0));
        tick();
        rst      = 1'b1;
        rd_vld   = 4'b1111;
        ar_ready = 1'b1;
        #1;
        check("post_rst_rdy", 256'(rd_rdy), 256'(4'b0001));
        tick();
        check("post_rst_ar_id", 256'(ar_id), 256'(8'h10));
        rd_vld = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/engine_read_arbiter.md
# engine_read_arbiter

Shares one AXI read channel between NUM_ENGINES Smith-Waterman engines. Each engine's reference-reader read-request and read-data ports connect here. The block picks engine requests round-robin, tags each burst ID with the engine index, and caps the bursts outstanding per engine. Returning data is routed to its owning engine by the ID tag.

## Interface
- NUM_ENGINES, 4: engines served, 2..4.
- ENG_W, 2: engine-index width in the downstream ID; 2^ENG_W >= NUM_ENGINES.
- MAX_OUTSTANDING, 8: bursts allowed in flight per engine, 1..15.
- clk  in  1  single clock domain for the whole block.
- rst  in  1  asynchronous, active-low reset.
- rd_id_in  in  6*NUM_ENGINES  per-engine burst ID; engine i uses bits [6i+5:6i].
- rd_addr_in  in  33*NUM_ENGINES  per-engine burst address.
- rd_len_in  in  8*NUM_ENGINES  per-engine burst length, in 256-bit beats.
- rd_info_valid_in  in  NUM_ENGINES  per-engine request valid.
- rd_info_rdy_out  out  NUM_ENGINES  per-engine request accepted.
- rd_data_out  out  256  read data, broadcast to all engines.
- rd_data_valid_out  out  NUM_ENGINES  data valid for engine i.
- rd_data_rdy_in  in  NUM_ENGINES  engine i accepts data.
- ar_id_out  out  6+ENG_W  downstream burst ID, {engine index, engine ID}.
- ar_addr_out  out  33  downstream burst address.
- ar_len_out  out  8  downstream burst length.
- ar_valid_out  out  1  downstream request valid.
- ar_ready_in  in  1  downstream request accepted.
- r_id_in  in  6+ENG_W  returning beat ID.
- r_data_in  in  256  returning beat data.
- r_last_in  in  1  last beat of a burst.
- r_valid_in  in  1  returning beat valid.
- r_ready_out  out  1  returning beat accepted.
- err_bad_id_out  out  1  sticky flag: a beat arrived with an out-of-range engine index.

## Operation
- Request register: a single holding slot. State EMPTY has ar_valid_out=0; state FULL has ar_valid_out=1.
- Slot loads when it is EMPTY, or FULL with ar_ready_in=1 in the same cycle. Back-to-back bursts therefore run at one per cycle.
- Eligible engine: rd_info_valid_in[i]=1 and cnt[i] < MAX_OUTSTANDING.
- Winner: the first eligible engine scanning from rr_ptr upward, wrapping at NUM_ENGINES-1.
- On a load:
  - rd_info_rdy_out[winner]=1, combinationally in that cycle; all other rdy bits are 0.
  - Slot captures {winner, rd_id}, rd_addr and rd_len.
  - rr_ptr becomes winner+1, mod NUM_ENGINES.
  - cnt[winner] increments.
- Slot drains on ar_valid_out && ar_ready_in. With no eligible engine at that point, the state returns to EMPTY.
- ar_* outputs stay stable while FULL and not accepted.
- Return path is purely combinational, with no buffering. Let e = r_id_in[6+ENG_W-1:6].
  - For e < NUM_ENGINES: rd_data_valid_out[e]=r_valid_in and r_ready_out=rd_data_rdy_in[e]. All other valid bits are 0, and rd_data_out=r_data_in.
  - For e >= NUM_ENGINES: r_ready_out=1 and the beat is dropped. If r_valid_in=1, err_bad_id_out is set and stays set until reset.
- cnt[e] decrements on the handshake r_valid_in && r_ready_out && r_last_in, when e is in range.
- If cnt[e] increments and decrements in the same cycle, it is unchanged.
- A decrement at cnt=0 is ignored (saturates).
- The 6-bit engine ID passes through untouched. The engine strips nothing.

## Timing
- Reset (rst=0, asynchronous):
  - ar_valid_out=0, ar_id/addr/len=0.
  - rd_info_rdy_out=0.
  - rr_ptr=0, all cnt=0, err_bad_id_out=0, state EMPTY.
- Combinational outputs under reset: rd_data_valid_out is forced 0, r_ready_out is 0, and rd_info_rdy_out is 0.
- Request latency: an accept in cycle N gives ar_valid_out=1 in cycle N+1.
- Return latency: 0 cycles.
- A decrement in cycle N makes a full engine eligible in cycle N+1.
- Reset mid-burst discards in-flight bookkeeping. Downstream must be reset together with this block.

## Test plan
- Single request:
  - Stimulus: engine 0 presents id=5, addr=0x100, len=3; ar_ready=1.
  - Response: rd_info_rdy_out=4'b0001 in the same cycle.
  - Next cycle: ar_valid=1, ar_id=8'h05, ar_addr=0x100, ar_len=3.
- Fairness: all 4 engines valid continuously, ar_ready=1 → grants in order 0,1,2,3,0,1, one per cycle.
- Back-pressure: ar_ready=0 for 5 cycles → ar_* held stable, no further rd_info_rdy_out pulses, then release resumes.
- Outstanding limit:
  - Engine 1 receives 8 grants with no r_last. Its 9th request gets rdy=0 while other engines keep being served.
  - A beat with r_id={2'd1,6'd0}, r_last=1, valid/ready → engine 1 is granted next cycle.
- Routing:
  - Beat with r_id={2'd2,6'd9}, r_valid=1 → only rd_data_valid_out[2]=1.
  - rd_data_rdy_in[2]=0 → r_ready_out=0.
- Bad ID and reset:
  - With NUM_ENGINES=3, a beat with r_id upper bits=3 → r_ready_out=1 and err_bad_id_out=1 thereafter.
  - rst=0 asserted while FULL → ar_valid_out=0 immediately, err cleared.
